// File: rtl/seq_run_detect.sv
// Serial run detector: flags runs of RUN_LEN equal bits (1s, 0s or either, selected by mode),
// with a first-reach strobe and a saturating event counter.
module seq_run_detect #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clr_cnt,
  output logic             z,
  output logic             z_pol,
  output logic             z_pulse,
  output logic [7:0]       run_len,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [7:0]       RUN_MAX = 8'(RUN_LEN);
  localparam logic [7:0]       RUN_PRE = 8'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             last_bit, last_bit_nxt;
  logic [7:0]       run_cnt, run_cnt_nxt;
  logic             pulse_nxt;
  logic [CNT_W-1:0] match_cnt_nxt;

  function automatic logic polarity_ok(input logic b, input logic [1:0] m);
    case (m)
      2'b00:   return b;
      2'b01:   return ~b;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] sat_run(input logic [7:0] c);
    return (c == RUN_MAX) ? c : c + 8'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_bit  <= 1'b0;
      run_cnt   <= 8'd0;
      z_pulse   <= 1'b0;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_bit  <= last_bit_nxt;
      run_cnt   <= run_cnt_nxt;
      z_pulse   <= pulse_nxt;
      match_cnt <= match_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_bit_nxt  = last_bit;
    run_cnt_nxt   = run_cnt;
    pulse_nxt     = 1'b0;
    match_cnt_nxt = match_cnt;
    if (en) begin
      case (state)
        IDLE: begin
          state_nxt    = TRACK;
          last_bit_nxt = w;
          run_cnt_nxt  = 8'd1;
        end
        TRACK: begin
          if (w == last_bit) begin
            run_cnt_nxt = sat_run(run_cnt);
            // Strobe only on the transition into a full run; a held full run never re-fires.
            pulse_nxt   = (run_cnt == RUN_PRE) && polarity_ok(last_bit, mode);
          end else begin
            last_bit_nxt = w;
            run_cnt_nxt  = 8'd1;
          end
        end
      endcase
    end
    if (clr_cnt)
      match_cnt_nxt = CNT_W'(pulse_nxt);
    else if (pulse_nxt)
      match_cnt_nxt = sat_cnt(match_cnt);
  end

  // mode is applied live so a mode change can toggle z without a new sample.
  assign z       = (state == TRACK) && (run_cnt == RUN_MAX) && polarity_ok(last_bit, mode);
  assign z_pol   = last_bit;
  assign run_len = run_cnt;

endmodule

// File: tb/tb_seq_run_detect.sv
// Directed bench for seq_run_detect: default instance plus CNT_W=2 and RUN_LEN=2 variants
// driven from the same stimulus.
module tb_seq_run_detect;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic w = 1'b0;
  logic [1:0] mode = 2'b00;
  logic clr_cnt = 1'b0;

  logic       z, z_pol, z_pulse;
  logic [7:0] run_len;
  logic [7:0] match_cnt;
  logic       c2_z, c2_pol, c2_pulse;
  logic [7:0] c2_run_len;
  logic [1:0] c2_cnt;
  logic       r2_z, r2_pol, r2_pulse;
  logic [7:0] r2_run_len;
  logic [7:0] r2_cnt;

  int vectors = 0;
  int errors  = 0;

  seq_run_detect u_dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
    .z(z), .z_pol(z_pol), .z_pulse(z_pulse), .run_len(run_len), .match_cnt(match_cnt)
  );

  seq_run_detect #(.RUN_LEN(4), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
    .z(c2_z), .z_pol(c2_pol), .z_pulse(c2_pulse), .run_len(c2_run_len), .match_cnt(c2_cnt)
  );

  seq_run_detect #(.RUN_LEN(2), .CNT_W(8)) u_r2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clr_cnt(clr_cnt),
    .z(r2_z), .z_pol(r2_pol), .z_pulse(r2_pulse), .run_len(r2_run_len), .match_cnt(r2_cnt)
  );

  always #5 clk = ~clk;

  // Apply one sample and land 1 ns after the rising edge.
  task automatic step(input logic e, input logic b);
    en = e;
    w  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b1;
    w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z got %0b want 0", z); end
    vectors++; if (z_pol !== 1'b0) begin errors++; $display("FAIL reset_zpol got %0b want 0", z_pol); end
    vectors++; if (z_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", z_pulse); end
    vectors++; if (run_len !== 8'd0) begin errors++; $display("FAIL reset_runlen got %0d want 0", run_len); end
    vectors++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    en = 1'b0;
    reset = 1'b0;
    step(1'b0, 1'b1);
    vectors++; if (run_len !== 8'd0) begin errors++; $display("FAIL idle_hold_runlen got %0d want 0", run_len); end
  endtask

  task automatic test_run_ones();
    do_reset();
    mode = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1);
      vectors++; if (run_len !== 8'((k > 4) ? 4 : k)) begin errors++; $display("FAIL ones_runlen[%0d] got %0d want %0d", k, run_len, (k > 4) ? 4 : k); end
      vectors++; if (z !== (k >= 4)) begin errors++; $display("FAIL ones_z[%0d] got %0b want %0b", k, z, k >= 4); end
      vectors++; if (z_pulse !== (k == 4)) begin errors++; $display("FAIL ones_pulse[%0d] got %0b want %0b", k, z_pulse, k == 4); end
    end
    vectors++; if (z_pol !== 1'b1) begin errors++; $display("FAIL ones_zpol got %0b want 1", z_pol); end
    vectors++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL ones_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_run_zeros();
    int ws[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int rl[8] = '{1, 2, 3, 1, 1, 2, 3, 4};
    do_reset();
    mode = 2'b01;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, ws[k][0]);
      vectors++; if (run_len !== 8'(rl[k])) begin errors++; $display("FAIL zeros_runlen[%0d] got %0d want %0d", k, run_len, rl[k]); end
      vectors++; if (z !== (k == 7)) begin errors++; $display("FAIL zeros_z[%0d] got %0b want %0b", k, z, k == 7); end
      vectors++; if (z_pol !== ws[k][0]) begin errors++; $display("FAIL zeros_zpol[%0d] got %0b want %0b", k, z_pol, ws[k][0]); end
    end
    vectors++; if (z_pulse !== 1'b1) begin errors++; $display("FAIL zeros_pulse got %0b want 1", z_pulse); end
  endtask

  task automatic test_either();
    int ws[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int rl[8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    do_reset();
    mode = 2'b10;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, ws[k][0]);
      vectors++; if (run_len !== 8'(rl[k])) begin errors++; $display("FAIL either_runlen[%0d] got %0d want %0d", k, run_len, rl[k]); end
      vectors++; if (z_pulse !== (k == 3 || k == 7)) begin errors++; $display("FAIL either_pulse[%0d] got %0b want %0b", k, z_pulse, k == 3 || k == 7); end
      vectors++; if (z !== (k == 3 || k == 7)) begin errors++; $display("FAIL either_z[%0d] got %0b want %0b", k, z, k == 3 || k == 7); end
      vectors++; if (z_pol !== ws[k][0]) begin errors++; $display("FAIL either_zpol[%0d] got %0b want %0b", k, z_pol, ws[k][0]); end
    end
    vectors++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL either_cnt got %0d want 2", match_cnt); end
  endtask

  task automatic test_enable();
    int rl[7] = '{1, 1, 2, 2, 3, 3, 4};
    do_reset();
    mode = 2'b00;
    for (int k = 0; k < 7; k++) begin
      step((k % 2) == 0, 1'b1);
      vectors++; if (run_len !== 8'(rl[k])) begin errors++; $display("FAIL en_runlen[%0d] got %0d want %0d", k, run_len, rl[k]); end
      vectors++; if (z_pulse !== (k == 6)) begin errors++; $display("FAIL en_pulse[%0d] got %0b want %0b", k, z_pulse, k == 6); end
    end
    clr_cnt = 1'b1;
    step(1'b0, 1'b0);
    clr_cnt = 1'b0;
    vectors++; if (z_pulse !== 1'b0) begin errors++; $display("FAIL en_hold_pulse got %0b want 0", z_pulse); end
    vectors++; if (z !== 1'b1) begin errors++; $display("FAIL en_hold_z got %0b want 1", z); end
    vectors++; if (run_len !== 8'd4) begin errors++; $display("FAIL en_hold_runlen got %0d want 4", run_len); end
    vectors++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL en_clr_cnt got %0d want 0", match_cnt); end
  endtask

  task automatic test_mode_change();
    do_reset();
    mode = 2'b00;
    repeat (4) step(1'b1, 1'b1);
    mode = 2'b01;
    #1;
    vectors++; if (z !== 1'b0) begin errors++; $display("FAIL mode_z_off got %0b want 0", z); end
    step(1'b1, 1'b1);
    vectors++; if (z_pulse !== 1'b0) begin errors++; $display("FAIL mode_pulse_a got %0b want 0", z_pulse); end
    mode = 2'b00;
    #1;
    vectors++; if (z !== 1'b1) begin errors++; $display("FAIL mode_z_on got %0b want 1", z); end
    step(1'b1, 1'b1);
    vectors++; if (z_pulse !== 1'b0) begin errors++; $display("FAIL mode_pulse_b got %0b want 0", z_pulse); end
    vectors++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL mode_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_short_run();
    do_reset();
    mode = 2'b00;
    step(1'b1, 1'b1);
    vectors++; if (r2_z !== 1'b0) begin errors++; $display("FAIL r2_z_first got %0b want 0", r2_z); end
    step(1'b1, 1'b1);
    vectors++; if (r2_z !== 1'b1) begin errors++; $display("FAIL r2_z got %0b want 1", r2_z); end
    vectors++; if (r2_pulse !== 1'b1) begin errors++; $display("FAIL r2_pulse got %0b want 1", r2_pulse); end
    vectors++; if (r2_run_len !== 8'd2) begin errors++; $display("FAIL r2_runlen got %0d want 2", r2_run_len); end
    step(1'b1, 1'b1);
    vectors++; if (r2_pulse !== 1'b0) begin errors++; $display("FAIL r2_pulse_hold got %0b want 0", r2_pulse); end
    vectors++; if (r2_cnt !== 8'd1) begin errors++; $display("FAIL r2_cnt got %0d want 1", r2_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    mode = 2'b10;
    for (int r = 0; r < 5; r++)
      repeat (4) step(1'b1, (r % 2) == 0);
    vectors++; if (c2_cnt !== 2'd3) begin errors++; $display("FAIL sat_c2_cnt got %0d want 3", c2_cnt); end
    vectors++; if (match_cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt got %0d want 5", match_cnt); end
    repeat (3) step(1'b1, 1'b0);
    clr_cnt = 1'b1;
    step(1'b1, 1'b0);
    vectors++; if (c2_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got %0b want 1", c2_pulse); end
    vectors++; if (c2_cnt !== 2'd1) begin errors++; $display("FAIL clr_pulse_c2_cnt got %0d want 1", c2_cnt); end
    vectors++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL clr_pulse_cnt got %0d want 1", match_cnt); end
    step(1'b1, 1'b0);
    clr_cnt = 1'b0;
    vectors++; if (c2_cnt !== 2'd0) begin errors++; $display("FAIL clr_plain_cnt got %0d want 0", c2_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 2'b00;
    repeat (3) step(1'b1, 1'b1);
    vectors++; if (run_len !== 8'd3) begin errors++; $display("FAIL ar_pre_runlen got %0d want 3", run_len); end
    reset = 1'b1;
    #2;
    vectors++; if (run_len !== 8'd0) begin errors++; $display("FAIL ar_runlen got %0d want 0", run_len); end
    vectors++; if (z_pol !== 1'b0) begin errors++; $display("FAIL ar_zpol got %0b want 0", z_pol); end
    vectors++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got %0d want 0", match_cnt); end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1);
      vectors++; if (run_len !== 8'(k)) begin errors++; $display("FAIL ar_runlen[%0d] got %0d want %0d", k, run_len, k); end
      vectors++; if (z !== (k == 4)) begin errors++; $display("FAIL ar_z[%0d] got %0b want %0b", k, z, k == 4); end
    end
  endtask

  initial begin
    test_reset();
    test_run_ones();
    test_run_zeros();
    test_either();
    test_enable();
    test_mode_change();
    test_short_run();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
